// File: rtl/md_unit_ctrl.sv
// Multi-cycle multiply/divide sequencer owning HI/LO, placed in the E stage.
// Optional accumulate ops (madd/maddu) are enabled by defining MD_MADD_EN.
module md_unit_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  md_op,
    input  logic        flush,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        md_use_d,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_MULT = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] CNT_DIV  = CW'(DIV_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV
    } state_e;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MADD  = 4'd7,
        OP_MADDU = 4'd8
    } md_op_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic [63:0]   res_q, res_d;
    logic          acc_q, acc_d;
    logic          wr_q, wr_d;

    logic        is_mul, is_acc, is_div, is_signed;
    logic        can_issue, start, mt_hi, mt_lo, busy_w;
    logic [32:0] a_ext, b_ext, b_div;
    logic [63:0] a_wide, b_wide, prod;
    logic [31:0] quot, rem;
    logic        div_zero;

    always_comb begin
        is_mul    = md_op inside {OP_MULT, OP_MULTU};
`ifdef MD_MADD_EN
        is_acc    = md_op inside {OP_MADD, OP_MADDU};
`else
        is_acc    = 1'b0;
`endif
        is_div    = md_op inside {OP_DIV, OP_DIVU};
        is_signed = md_op inside {OP_MULT, OP_DIV, OP_MADD};
        can_issue = !flush && (state_q == ST_IDLE);
        start     = can_issue && (is_mul || is_acc || is_div);
        mt_hi     = can_issue && (md_op == OP_MTHI);
        mt_lo     = can_issue && (md_op == OP_MTLO);
    end

    // Operands are extended to 33 bits so one signed datapath covers both
    // signed and unsigned forms, including -2^31 / -1 without overflow.
    always_comb begin
        a_ext    = {is_signed & rs_val[31], rs_val};
        b_ext    = {is_signed & rt_val[31], rt_val};
        a_wide   = {{31{a_ext[32]}}, a_ext};
        b_wide   = {{31{b_ext[32]}}, b_ext};
        prod     = a_wide * b_wide;
        div_zero = (rt_val == '0);
        b_div    = div_zero ? 33'd1 : b_ext;
        quot     = 32'($signed(a_ext) / $signed(b_div));
        rem      = 32'($signed(a_ext) % $signed(b_div));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            res_q   <= '0;
            acc_q   <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            res_q   <= res_d;
            acc_q   <= acc_d;
            wr_q    <= wr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = is_div ? ST_DIV : ST_MUL;
                end
            end
            ST_MUL, ST_DIV: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_w = (state_q != ST_IDLE);
        busy   = busy_w;
        stall  = md_use_d && (start || busy_w);
        hi     = hi_q;
        lo     = lo_q;
    end

    // Result is captured at issue; the accumulate sum uses HI/LO at completion.
    always_comb begin
        cnt_d = cnt_q;
        res_d = res_q;
        acc_d = acc_q;
        wr_d  = wr_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        if (start) begin
            cnt_d = is_div ? CNT_DIV : CNT_MULT;
            res_d = is_div ? {rem, quot} : prod;
            acc_d = is_acc;
            wr_d  = !(is_div && div_zero);
        end else if (busy_w) begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE && wr_q) begin
                {hi_d, lo_d} = acc_q ? ({hi_q, lo_q} + res_q) : res_q;
            end
        end
        if (mt_hi) begin
            hi_d = rs_val;
        end
        if (mt_lo) begin
            lo_d = rs_val;
        end
    end

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Self-checking bench for md_unit_ctrl: directed scenarios plus randomized
// traffic against a pending-result reference model (MD_MADD_EN aware).
module tb_md_unit_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  md_op = '0;
    logic        flush = 1'b0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        md_use_d = 1'b0;
    logic        busy, stall;
    logic [31:0] hi, lo;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    logic [31:0] m_hi = '0, m_lo = '0;
    int          m_left = 0;
    logic [63:0] m_res = '0;
    bit          m_acc = 0, m_wr = 0;

    md_unit_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .md_op(md_op), .flush(flush),
        .rs_val(rs_val), .rt_val(rt_val), .md_use_d(md_use_d),
        .busy(busy), .stall(stall), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    function automatic bit op_starts(input logic [3:0] op);
`ifdef MD_MADD_EN
        return op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8};
`else
        return op inside {4'd1, 4'd2, 4'd3, 4'd4};
`endif
    endfunction

    function automatic bit m_start();
        return !flush && (m_left == 0) && op_starts(md_op);
    endfunction

    task automatic model_edge();
        int     ia, ib;
        longint sa, sb, ua, ub, q, r;
        ia = rs_val; ib = rt_val;
        sa = ia;     sb = ib;
        ua = {32'd0, rs_val};
        ub = {32'd0, rt_val};
        if (reset) begin
            m_hi = '0; m_lo = '0; m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && m_wr)
                {m_hi, m_lo} = m_acc ? ({m_hi, m_lo} + m_res) : m_res;
        end else if (!flush) begin
            if (op_starts(md_op)) begin
                m_acc = (md_op == 4'd7 || md_op == 4'd8);
                m_wr  = 1;
                case (md_op)
                    4'd1, 4'd7: begin m_res = sa * sb; m_left = 5; end
                    4'd2, 4'd8: begin m_res = ua * ub; m_left = 5; end
                    4'd3: begin
                        m_left = 10;
                        if (rt_val == 0) m_wr = 0;
                        else begin q = sa / sb; r = sa % sb; m_res = {r[31:0], q[31:0]}; end
                    end
                    default: begin
                        m_left = 10;
                        if (rt_val == 0) m_wr = 0;
                        else begin q = ua / ub; r = ua % ub; m_res = {r[31:0], q[31:0]}; end
                    end
                endcase
            end else if (md_op == 4'd5) m_hi = rs_val;
            else if (md_op == 4'd6) m_lo = rs_val;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        md_op = op; rs_val = a; rt_val = b;
        tick();
        md_op = '0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 64) begin
            n++;
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; md_op = 4'd1; rs_val = 32'd3; rt_val = 32'd5; md_use_d = 1'b0;
        tick();
        reset = 1'b0; md_op = '0;
        #1;
        n_cmp++; if (hi !== 32'd0) begin n_bad++; $display("FAIL reset_hi got %h want %h", hi, 32'd0); end
        n_cmp++; if (lo !== 32'd0) begin n_bad++; $display("FAIL reset_lo got %h want %h", lo, 32'd0); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_no_start got %b want 0", busy); end
    endtask

    task automatic test_mult();
        int n;
        issue(4'd1, 32'hFFFF_FFFD, 32'd5);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mult_busy_start got %b want 1", busy); end
        wait_idle(n);
        n_cmp++; if (n != 5) begin n_bad++; $display("FAIL mult_busy_len got %0d want 5", n); end
        n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL mult_hi got %h want ffffffff", hi); end
        n_cmp++; if (lo !== 32'hFFFF_FFF1) begin n_bad++; $display("FAIL mult_lo got %h want fffffff1", lo); end
    endtask

    task automatic test_div();
        int n;
        issue(4'd4, 32'd7, 32'd2);
        wait_idle(n);
        n_cmp++; if (n != 10) begin n_bad++; $display("FAIL divu_busy_len got %0d want 10", n); end
        n_cmp++; if (hi !== 32'd1) begin n_bad++; $display("FAIL divu_hi got %h want 1", hi); end
        n_cmp++; if (lo !== 32'd3) begin n_bad++; $display("FAIL divu_lo got %h want 3", lo); end
        issue(4'd3, 32'hFFFF_FFF9, 32'd2);
        wait_idle(n);
        n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL div_hi got %h want ffffffff", hi); end
        n_cmp++; if (lo !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL div_lo got %h want fffffffd", lo); end
    endtask

    task automatic test_stall();
        int n;
        md_use_d = 1'b1; md_op = 4'd1; rs_val = 32'd6; rt_val = 32'd7;
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL stall_start got %b want 1", stall); end
        tick();
        md_op = '0;
        n = 0;
        while (busy === 1'b1 && n < 64) begin
            #1;
            n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL stall_busy cycle %0d got %b want 1", n, stall); end
            n++;
            tick();
        end
        n_cmp++; if (n != 5) begin n_bad++; $display("FAIL stall_busy_len got %0d want 5", n); end
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL stall_release got %b want 0", stall); end
        n_cmp++; if (lo !== 32'd42) begin n_bad++; $display("FAIL stall_mflo got %h want 2a", lo); end
        md_use_d = 1'b0;
    endtask

    task automatic test_div_zero_and_flush();
        int n;
        issue(4'd5, 32'h11, 32'd0);
        issue(4'd6, 32'h22, 32'd0);
        issue(4'd3, 32'd9, 32'd0);
        wait_idle(n);
        n_cmp++; if (n != 10) begin n_bad++; $display("FAIL div0_busy_len got %0d want 10", n); end
        n_cmp++; if (hi !== 32'h11) begin n_bad++; $display("FAIL div0_hi got %h want 11", hi); end
        n_cmp++; if (lo !== 32'h22) begin n_bad++; $display("FAIL div0_lo got %h want 22", lo); end
        md_op = 4'd1; flush = 1'b1; md_use_d = 1'b1; rs_val = 32'd4; rt_val = 32'd4;
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL flush_stall got %b want 0", stall); end
        tick();
        md_op = '0; flush = 1'b0; md_use_d = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL flush_busy got %b want 0", busy); end
        n_cmp++; if ({hi, lo} !== {32'h11, 32'h22}) begin n_bad++; $display("FAIL flush_hilo got %h want 0000001100000022", {hi, lo}); end
    endtask

    task automatic test_flush_during_busy();
        int n;
        issue(4'd2, 32'd100, 32'd3);
        flush = 1'b1; md_op = 4'd6; rs_val = 32'hDEAD_BEEF;
        wait_idle(n);
        flush = 1'b0; md_op = '0;
        n_cmp++; if (n != 5) begin n_bad++; $display("FAIL flushbusy_len got %0d want 5", n); end
        n_cmp++; if ({hi, lo} !== 64'd300) begin n_bad++; $display("FAIL flushbusy_hilo got %h want 300", {hi, lo}); end
    endtask

    task automatic test_back_to_back();
        int n;
        issue(4'd1, 32'd2, 32'd3);
        md_op = 4'd5; rs_val = 32'hCAFE_0000;
        wait_idle(n);
        md_op = '0;
        n_cmp++; if ({hi, lo} !== 64'd6) begin n_bad++; $display("FAIL ignore_busy_op got %h want 6", {hi, lo}); end
        issue(4'd4, 32'd100, 32'd7);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_start got %b want 1", busy); end
        wait_idle(n);
        n_cmp++; if ({hi, lo} !== {32'd2, 32'd14}) begin n_bad++; $display("FAIL b2b_divu got %h want 000000020000000e", {hi, lo}); end
    endtask

    task automatic test_madd();
        int n;
        issue(4'd5, 32'd0, 32'd0);
        issue(4'd6, 32'hFFFF_FFFF, 32'd0);
        issue(4'd8, 32'd1, 32'd1);
`ifdef MD_MADD_EN
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL maddu_busy got %b want 1", busy); end
        wait_idle(n);
        n_cmp++; if ({hi, lo} !== {32'd1, 32'd0}) begin n_bad++; $display("FAIL maddu_hilo got %h want 0000000100000000", {hi, lo}); end
`else
        n = 0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL maddu_off_busy got %b want 0", busy); end
        n_cmp++; if ({hi, lo} !== {32'd0, 32'hFFFF_FFFF}) begin n_bad++; $display("FAIL maddu_off_hilo got %h want 00000000ffffffff", {hi, lo}); end
        md_op = 4'd7; md_use_d = 1'b1;
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL madd_off_stall got %b want 0 (%0d)", stall, n); end
        md_op = '0; md_use_d = 1'b0;
`endif
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        logic exp_stall;
        for (int i = 0; i < 600; i++) begin
            reset    = ($urandom_range(0, 99) == 0);
            flush    = ($urandom_range(0, 4) == 0);
            md_op    = 4'($urandom_range(0, 8));
            rs_val   = rand_operand();
            rt_val   = rand_operand();
            md_use_d = $urandom_range(0, 1) == 1;
            #1;
            exp_stall = md_use_d && (m_start() || m_left > 0);
            n_cmp++; if (stall !== exp_stall) begin n_bad++; $display("FAIL rnd_stall i=%0d got %b want %b", i, stall, exp_stall); end
            n_cmp++; if (busy !== (m_left > 0)) begin n_bad++; $display("FAIL rnd_busy i=%0d got %b want %b", i, busy, m_left > 0); end
            n_cmp++; if (hi !== m_hi) begin n_bad++; $display("FAIL rnd_hi i=%0d got %h want %h", i, hi, m_hi); end
            n_cmp++; if (lo !== m_lo) begin n_bad++; $display("FAIL rnd_lo i=%0d got %h want %h", i, lo, m_lo); end
            tick();
        end
        reset = 1'b0; flush = 1'b0; md_op = '0; md_use_d = 1'b0;
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_stall();
        test_div_zero_and_flush();
        test_flush_during_busy();
        test_back_to_back();
        test_madd();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
